key_dec_entry: RTL and testbench
================================

# key_dec_entry

Decimal keypad-entry decoder for the Basys3 calculator. Takes the debounced keypad code stream (`key_value`/`key_valid` from the keypad controller), collects up to `DIGITS` decimal digits in a BCD entry register for display, and on an operator/enter/clear key converts the entry to binary with a sequential reverse double-dabble engine. The operand and its terminating key code are then handed to the processor. It is the inverse of the display-side binary-to-BCD path.

## Interface
- `DIGITS`, 3: maximum decimal digits held.
- `WIDTH`, 10: binary operand width; must satisfy 2^WIDTH > 10^DIGITS − 1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_p`  in  1  asynchronous, active-low reset; the block is reset while 0.
- `key_value`  in  4  keypad code, valid while `key_valid`=1.
- `key_valid`  in  1  level, high while a key is held.
- `entry_bcd`  out  4*DIGITS  digits entered so far, least significant digit in [3:0]; unused upper digits 0.
- `digit_cnt`  out  2  number of digits held, 0..DIGITS.
- `busy`  out  1  conversion in progress.
- `num_out`  out  WIDTH  converted operand; held until the next conversion completes.
- `term_code`  out  4  key code that terminated the entry; held with `num_out`.
- `num_valid`  out  1  one-cycle pulse; `num_out`/`term_code` are new this cycle.

## Operation
- Press detection: `key_prev` registers `key_valid`. A press is a cycle with `key_valid`=1 and `key_prev`=0, and `key_value` is sampled in that cycle. Holding a key never repeats it.
- Key map:
  - 0x0–0x9 are digits.
  - 0xA–0xD are operators.
  - 0xE is enter.
  - 0xF is clear.
- States: IDLE, CONV, DONE.
- IDLE, digit press:
  - If `digit_cnt` < DIGITS: `entry_bcd` = {entry_bcd[4*DIGITS-5:0], key_value} and `digit_cnt`+1.
  - If `digit_cnt` = DIGITS: the digit is ignored and nothing changes.
  - Leading zeros are stored and counted.
- IDLE, clear (0xF): `entry_bcd`=0 and `digit_cnt`=0. There is no `num_valid`. `num_out` and `term_code` are unchanged.
- IDLE, operator or enter (0xA–0xE):
  - Latch the key into `term_code`.
  - Load shift register {bcd, bin} = {entry_bcd, WIDTH'b0} and set iteration counter = 0.
  - Go to CONV. An empty entry converts to 0.
- CONV, one iteration per cycle, WIDTH iterations:
  - Shift {bcd, bin} right by 1.
  - For each BCD nibble of the shifted result: if the nibble ≥ 8, subtract 3.
  - After iteration WIDTH−1, go to DONE.
- DONE (one cycle):
  - `num_out` = bin and `num_valid` = 1.
  - `entry_bcd` = 0 and `digit_cnt` = 0.
  - Go to IDLE.
- Presses detected in CONV or DONE are discarded. `key_prev` still tracks `key_valid`, so a key held across the end of a conversion does not register on return to IDLE.
- Arithmetic: the result equals the decimal value of the entry and is exact for any digit string up to DIGITS long. No saturation is needed, given the `WIDTH` constraint.

## Timing
- Reset values:
  - `entry_bcd`=0, `digit_cnt`=0, `busy`=0.
  - `num_out`=0, `term_code`=0, `num_valid`=0.
  - State IDLE and `key_prev`=0.
- `entry_bcd` and `digit_cnt` update on the clock edge ending the press-detect cycle, i.e. 1 cycle after `key_valid` rises.
- Terminating key: `busy`=1 from the edge ending the press-detect cycle until DONE is left. `busy`=1 also during DONE.
- `num_valid` pulses exactly WIDTH+1 cycles after the press-detect edge (11 cycles for the defaults), for 1 cycle.
- `entry_bcd`=0 from the same edge that ends DONE.
- Back-to-back: a new press detected in the first IDLE cycle after DONE is accepted.
- Reset mid-conversion: asynchronous return to reset values. No `num_valid` is produced for the aborted entry.
- A press and its release within one cycle (key_valid high exactly 1 cycle) is a valid press.

## Test plan
- Reset mid-CONV: press 5, 0xE, then pull `reset_p` low 4 cycles later -> all outputs take reset values immediately; no `num_valid` is seen. After release, press 0xE -> `num_out`=0, `num_valid` pulses.
- Keys 1, 2, 3, then 0xA (each 3-cycle press, 5-cycle gap) -> `entry_bcd`=0x123 and `digit_cnt`=3 before 0xA. Then `num_valid` 11 cycles after the 0xA detect edge, with `num_out`=123 and `term_code`=0xA; afterwards `entry_bcd`=0.
- Keys 9, 9, 9, 7, 0xE -> the 4th digit is ignored, `entry_bcd` stays 0x999 -> `num_out`=999, `term_code`=0xE.
- Keys 0, 4, 0xF, 8, 0xB -> the clear empties the entry with no pulse -> `num_out`=8, `term_code`=0xB.
- Key 7 held 30 cycles, with 0xE pressed while `busy` during a prior conversion -> the digit is captured once, and the 0xE press during `busy` is dropped with no second `num_valid`.
- 0xE pressed on an empty entry -> `num_out`=0 and `num_valid` pulses once.

Source files
------------

// File: rtl/key_dec_entry_if.sv
`default_nettype none
// ============================================================================
// Module      : key_dec_entry_if
// Description : Bundle between the keypad controller / processor side and the
//               decimal keypad-entry decoder.
//               master : drives key_value/key_valid, observes the outputs.
//               slave  : the decoder (samples keys, drives entry/operand).
//   key_value  [3:0]          keypad code, valid while key_valid
//   key_valid                 level, high while a key is held
//   entry_bcd  [4*DIGITS-1:0] digits entered so far, LS digit in [3:0]
//   digit_cnt  [1:0]          number of digits held
//   busy                      conversion in progress
//   num_out    [WIDTH-1:0]    converted operand
//   term_code  [3:0]          key that terminated the entry
//   num_valid                 one-cycle pulse, num_out/term_code new
// Revision    : 1.0 - initial release
// ============================================================================
interface key_dec_entry_if #(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 10
);
    logic [3:0]          key_value;
    logic                key_valid;
    logic [4*DIGITS-1:0] entry_bcd;
    logic [1:0]          digit_cnt;
    logic                busy;
    logic [WIDTH-1:0]    num_out;
    logic [3:0]          term_code;
    logic                num_valid;

    modport master (
        output key_value, key_valid,
        input  entry_bcd, digit_cnt, busy, num_out, term_code, num_valid
    );

    modport slave (
        input  key_value, key_valid,
        output entry_bcd, digit_cnt, busy, num_out, term_code, num_valid
    );
endinterface
`default_nettype wire

// File: rtl/key_dec_entry.sv
`default_nettype none
// ============================================================================
// Module      : key_dec_entry
// Description : Decimal keypad-entry decoder. Collects up to DIGITS BCD digits
//               from the keypad press stream, and on an operator/enter key
//               converts the entry to binary with a sequential reverse
//               double-dabble (one shift per cycle, WIDTH cycles), then hands
//               the operand and its terminating key to the processor.
//   clk      : system clock, rising edge
//   reset_p  : asynchronous reset, active low
//   bus      : key_dec_entry_if.slave (keys in; entry, busy, operand out)
// Revision    : 1.0 - initial release
// ============================================================================
module key_dec_entry #(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 10
) (
    input  wire logic        clk,
    input  wire logic        reset_p,
    key_dec_entry_if.slave   bus
);

    localparam int SH_W   = 4*DIGITS + WIDTH;
    localparam int ITER_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0]        C_MAX_DIGITS = 2'(DIGITS);
    localparam logic [ITER_W-1:0] C_LAST_ITER  = ITER_W'(WIDTH - 1);

    logic [1:0]          r_state;
    logic                r_key_prev;
    logic [4*DIGITS-1:0] r_entry_bcd;
    logic [1:0]          r_digit_cnt;
    logic                r_busy;
    logic [WIDTH-1:0]    r_num_out;
    logic [3:0]          r_term_code;
    logic                r_num_valid;
    logic [SH_W-1:0]     r_shift;
    logic [ITER_W-1:0]   r_iter;

    logic                w_press;
    logic                w_is_digit;
    logic [4*DIGITS-1:0] w_entry_next;
    logic [SH_W-1:0]     w_shr;
    logic [SH_W-1:0]     w_corr;

    // Rising edge of key_valid; key_prev keeps tracking in every state so a
    // key held through a conversion never fires when IDLE is re-entered.
    assign w_press    = bus.key_valid & ~r_key_prev;
    assign w_is_digit = (bus.key_value <= 4'd9);

    // New digit enters at the least significant nibble.
    generate
        if (DIGITS > 1) begin : g_shift_multi
            assign w_entry_next = {r_entry_bcd[4*DIGITS-5:0], bus.key_value};
        end else begin : g_shift_single
            assign w_entry_next = bus.key_value;
        end
    endgenerate

    // One reverse double-dabble step: shift {bcd,bin} right, then any BCD
    // nibble that is now >= 8 held a 10 that became 16/2, so subtract 3.
    assign w_shr = r_shift >> 1;
    assign w_corr[WIDTH-1:0] = w_shr[WIDTH-1:0];

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_nib
            logic [3:0] w_nib;
            assign w_nib = w_shr[WIDTH + 4*i +: 4];
            assign w_corr[WIDTH + 4*i +: 4] = (w_nib >= 4'd8) ? (w_nib - 4'd3) : w_nib;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_p) begin
        if (!reset_p) begin
            r_state     <= S_IDLE;
            r_key_prev  <= 1'b0;
            r_entry_bcd <= '0;
            r_digit_cnt <= 2'd0;
            r_busy      <= 1'b0;
            r_num_out   <= '0;
            r_term_code <= 4'd0;
            r_num_valid <= 1'b0;
            r_shift     <= '0;
            r_iter      <= '0;
        end else begin
            r_key_prev  <= bus.key_valid;
            r_num_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        if (w_is_digit) begin
                            // A full entry silently drops further digits.
                            if (r_digit_cnt < C_MAX_DIGITS) begin
                                r_entry_bcd <= w_entry_next;
                                r_digit_cnt <= r_digit_cnt + 2'd1;
                            end
                        end else if (bus.key_value == 4'hF) begin
                            r_entry_bcd <= '0;
                            r_digit_cnt <= 2'd0;
                        end else begin
                            r_term_code <= bus.key_value;
                            r_shift     <= {r_entry_bcd, {WIDTH{1'b0}}};
                            r_iter      <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= S_CONV;
                        end
                    end
                end

                S_CONV: begin
                    r_shift <= w_corr;
                    if (r_iter == C_LAST_ITER) begin
                        r_state <= S_DONE;
                    end else begin
                        r_iter <= r_iter + 1'b1;
                    end
                end

                S_DONE: begin
                    // All DONE effects land on the edge that leaves DONE.
                    r_num_out   <= r_shift[WIDTH-1:0];
                    r_num_valid <= 1'b1;
                    r_entry_bcd <= '0;
                    r_digit_cnt <= 2'd0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.entry_bcd = r_entry_bcd;
    assign bus.digit_cnt = r_digit_cnt;
    assign bus.busy      = r_busy;
    assign bus.num_out   = r_num_out;
    assign bus.term_code = r_term_code;
    assign bus.num_valid = r_num_valid;

endmodule
`default_nettype wire

// File: tb/tb_key_dec_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_dec_entry
// Description : Directed self-checking bench for key_dec_entry (DIGITS=3,
//               WIDTH=10). Inputs change and outputs are sampled on the
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_dec_entry;

    localparam int DIGITS = 3;
    localparam int WIDTH  = 10;

    logic clk;
    logic reset_p;
    int   n_tests;
    int   n_fail;
    int   n_pulse;
    int   exp_pulse;

    key_dec_entry_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

    key_dec_entry #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every num_valid pulse, expected or not.
    always @(negedge clk) begin
        if (bus.num_valid === 1'b1) n_pulse++;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns on a falling edge.
    task automatic press_key(input logic [3:0] code, input int hold, input int gap);
        bus.key_value = code;
        bus.key_valid = 1'b1;
        repeat (hold) @(negedge clk);
        bus.key_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Terminating key: checks busy, latency (num_valid on the 12th falling
    // edge after key_valid rises = WIDTH+1 cycles after the detect edge),
    // operand and key code. With extra set, a second 0xE is pressed mid-CONV.
    // Returns on the falling edge where num_valid is seen.
    task automatic term_press(input string tag, input logic [3:0] code,
                              input logic [9:0] exp_num, input bit extra);
        int  cyc;
        bit  seen;
        cyc  = 0;
        seen = 1'b0;
        bus.key_value = code;
        bus.key_valid = 1'b1;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check_value({tag, "_busy"}, 32'(bus.busy), 32'd1);
            if (cyc == 3) bus.key_valid = 1'b0;
            if (extra && cyc == 5) begin
                bus.key_value = 4'hE;
                bus.key_valid = 1'b1;
            end
            if (extra && cyc == 7) bus.key_valid = 1'b0;
            if (bus.num_valid === 1'b1) begin
                seen = 1'b1;
                check_value({tag, "_lat"},  32'(cyc),           32'd12);
                check_value({tag, "_num"},  32'(bus.num_out),   32'(exp_num));
                check_value({tag, "_term"}, 32'(bus.term_code), 32'(code));
                check_value({tag, "_idle"}, 32'(bus.busy),      32'd0);
                check_value({tag, "_clr"},  32'(bus.entry_bcd), 32'd0);
                check_value({tag, "_cnt"},  32'(bus.digit_cnt), 32'd0);
            end
        end
        if (!seen) check_value({tag, "_timeout"}, 32'd0, 32'd1);
        exp_pulse++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        n_pulse   = 0;
        exp_pulse = 0;
        reset_p   = 1'b0;
        bus.key_value = 4'd0;
        bus.key_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check_value("rst_entry", 32'(bus.entry_bcd), 32'd0);
        check_value("rst_cnt",   32'(bus.digit_cnt), 32'd0);
        check_value("rst_busy",  32'(bus.busy),      32'd0);
        check_value("rst_num",   32'(bus.num_out),   32'd0);
        check_value("rst_term",  32'(bus.term_code), 32'd0);
        check_value("rst_nv",    32'(bus.num_valid), 32'd0);
        reset_p = 1'b1;
        @(negedge clk);

        // Reset in the middle of a conversion.
        press_key(4'd5, 3, 5);
        check_value("mid_entry5", 32'(bus.entry_bcd), 32'h005);
        bus.key_value = 4'hE;
        bus.key_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.key_valid = 1'b0;
        @(negedge clk);
        check_value("mid_busy", 32'(bus.busy), 32'd1);
        #2 reset_p = 1'b0;
        #1;
        check_value("mid_entry", 32'(bus.entry_bcd), 32'd0);
        check_value("mid_cnt",   32'(bus.digit_cnt), 32'd0);
        check_value("mid_idle",  32'(bus.busy),      32'd0);
        check_value("mid_term",  32'(bus.term_code), 32'd0);
        check_value("mid_num",   32'(bus.num_out),   32'd0);
        check_value("mid_nv",    32'(bus.num_valid), 32'd0);
        repeat (4) @(negedge clk);
        reset_p = 1'b1;
        repeat (20) @(negedge clk);
        #1 check_value("mid_nopulse", 32'(n_pulse), 32'(exp_pulse));
        term_press("mid_empty", 4'hE, 10'd0, 1'b0);
        @(negedge clk);

        // 1 2 3 then operator A.
        press_key(4'd1, 3, 5);
        check_value("e123_1", 32'(bus.entry_bcd), 32'h001);
        press_key(4'd2, 3, 5);
        press_key(4'd3, 3, 5);
        check_value("e123_bcd", 32'(bus.entry_bcd), 32'h123);
        check_value("e123_cnt", 32'(bus.digit_cnt), 32'd3);
        term_press("e123", 4'hA, 10'd123, 1'b0);
        @(negedge clk);

        // Fourth digit ignored.
        press_key(4'd9, 3, 5);
        press_key(4'd9, 3, 5);
        press_key(4'd9, 3, 5);
        press_key(4'd7, 3, 5);
        check_value("e999_bcd", 32'(bus.entry_bcd), 32'h999);
        check_value("e999_cnt", 32'(bus.digit_cnt), 32'd3);
        term_press("e999", 4'hE, 10'd999, 1'b0);
        @(negedge clk);

        // Leading zero counted, then clear.
        press_key(4'd0, 3, 5);
        press_key(4'd4, 3, 5);
        check_value("e04_bcd", 32'(bus.entry_bcd), 32'h004);
        check_value("e04_cnt", 32'(bus.digit_cnt), 32'd2);
        press_key(4'hF, 3, 5);
        check_value("clr_bcd", 32'(bus.entry_bcd), 32'd0);
        check_value("clr_cnt", 32'(bus.digit_cnt), 32'd0);
        check_value("clr_num", 32'(bus.num_out),   32'd999);
        check_value("clr_term", 32'(bus.term_code), 32'hE);
        #1 check_value("clr_nopulse", 32'(n_pulse), 32'(exp_pulse));
        press_key(4'd8, 3, 5);
        term_press("e8", 4'hB, 10'd8, 1'b0);
        @(negedge clk);

        // Long hold registers once; a press during busy is dropped.
        press_key(4'd7, 30, 5);
        check_value("hold_bcd", 32'(bus.entry_bcd), 32'h007);
        check_value("hold_cnt", 32'(bus.digit_cnt), 32'd1);
        term_press("hold", 4'hE, 10'd7, 1'b1);
        repeat (20) @(negedge clk);
        #1 check_value("busy_drop", 32'(n_pulse), 32'(exp_pulse));

        // Empty entry, then a one-cycle press in the first IDLE cycle.
        term_press("empty", 4'hE, 10'd0, 1'b0);
        bus.key_value = 4'd5;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        check_value("b2b_bcd", 32'(bus.entry_bcd), 32'h005);
        check_value("b2b_cnt", 32'(bus.digit_cnt), 32'd1);
        repeat (3) @(negedge clk);
        term_press("b2b", 4'hD, 10'd5, 1'b0);

        repeat (5) @(negedge clk);
        #1 check_value("pulse_total", 32'(n_pulse), 32'(exp_pulse));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
